// File: rtl/cache_assoc_wb_if.sv
// cache_assoc_wb_if: CPU request/response and block-wide memory bus of cache_assoc_wb
interface cache_assoc_wb_if #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS = 32,
    parameter int BLOCK_BITS = 2,
    parameter int COUNT_BITS = 16
);
    localparam int BLOCK_SIZE = 2 ** BLOCK_BITS;
    logic req_valid;
    logic req_ready;
    logic [RAM_ADDRESS_BITS-1:0] address;
    logic write_en;
    logic [DATA_BITS-1:0] write_data;
    logic resp_valid;
    logic [DATA_BITS-1:0] read_data;
    logic miss;
    logic mem_req_valid;
    logic mem_req_ready;
    logic mem_write_en;
    logic [RAM_ADDRESS_BITS-1:0] mem_address;
    logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] mem_write_data;
    logic mem_resp_valid;
    logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] mem_data;
    logic [COUNT_BITS-1:0] hit_count;
    logic [COUNT_BITS-1:0] miss_count;
    modport slave (
        input req_valid, address, write_en, write_data, mem_req_ready, mem_resp_valid, mem_data,
        output req_ready, resp_valid, read_data, miss, mem_req_valid, mem_write_en, mem_address,
        output mem_write_data, hit_count, miss_count
    );
    modport master (
        output req_valid, address, write_en, write_data, mem_req_ready, mem_resp_valid, mem_data,
        input req_ready, resp_valid, read_data, miss, mem_req_valid, mem_write_en, mem_address,
        input mem_write_data, hit_count, miss_count
    );
endinterface

// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: N-way set-associative write-back cache with true-LRU and a blocking miss FSM
module cache_assoc_wb #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int CACHE_ADDRESS_BITS = 5,
    parameter int DATA_BITS = 32,
    parameter int ASOC_BITS = 1,
    parameter int BLOCK_BITS = 2,
    parameter int COUNT_BITS = 16
) (
    input logic clk,
    input logic reset,
    cache_assoc_wb_if.slave bus
);
    localparam int ASOC_SIZE = 2 ** ASOC_BITS;
    localparam int BLOCK_SIZE = 2 ** BLOCK_BITS;
    localparam int INDEX_BITS = CACHE_ADDRESS_BITS - ASOC_BITS - BLOCK_BITS;
    localparam int TAG_BITS = RAM_ADDRESS_BITS - INDEX_BITS - BLOCK_BITS;
    localparam int SETS = 2 ** INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, WB_REQ, RF_REQ, RF_WAIT} state_t;
    typedef logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] block_t;

    state_t state;
    logic [RAM_ADDRESS_BITS-1:0] r_addr;
    logic r_we;
    logic [DATA_BITS-1:0] r_wd;
    logic first;
    logic [ASOC_BITS-1:0] vic;
    logic [ASOC_SIZE-1:0] valid [SETS];
    logic [ASOC_SIZE-1:0] dirty [SETS];
    logic [ASOC_BITS-1:0] age [ASOC_SIZE][SETS];
    logic [TAG_BITS-1:0] tags [ASOC_SIZE][SETS];
    block_t data [ASOC_SIZE][SETS];

    logic [BLOCK_BITS-1:0] off;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] rtag;
    logic hit;
    logic [ASOC_BITS-1:0] hway;
    logic [ASOC_BITS-1:0] vway;

    assign off = r_addr[BLOCK_BITS-1:0];
    assign idx = r_addr[BLOCK_BITS +: INDEX_BITS];
    assign rtag = r_addr[RAM_ADDRESS_BITS-1 -: TAG_BITS];
    assign bus.miss = state == LOOKUP && first && !hit;

    // Tag match in the request's set, and victim: lowest invalid way, else the oldest way
    always_comb begin
        hit = 1'b0;
        hway = '0;
        vway = '0;
        for (int w = 0; w < ASOC_SIZE; w++)
            if (valid[idx][w] && tags[w][idx] == rtag) begin
                hit = 1'b1;
                hway = ASOC_BITS'(w);
            end
        for (int w = 0; w < ASOC_SIZE; w++)
            if (age[w][idx] == '1) vway = ASOC_BITS'(w);
        for (int w = ASOC_SIZE - 1; w >= 0; w--)
            if (!valid[idx][w]) vway = ASOC_BITS'(w);
    end

    // Tag and block storage carry no reset; a refill or store hit writes them
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == LOOKUP && hit && r_we) data[hway][idx][off] <= r_wd;
            if (state == RF_WAIT && bus.mem_resp_valid) begin
                data[vic][idx] <= bus.mem_data;
                tags[vic][idx] <= rtag;
            end
        end
    end

    // Request sequencing, valid/dirty/LRU state, memory handshake and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bus.req_ready <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.read_data <= '0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_write_en <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_write_data <= '0;
            bus.hit_count <= '0;
            bus.miss_count <= '0;
            r_addr <= '0;
            r_we <= 1'b0;
            r_wd <= '0;
            first <= 1'b0;
            vic <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < ASOC_SIZE; w++) age[w][s] <= ASOC_BITS'(w);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr <= bus.address;
                        r_we <= bus.write_en;
                        r_wd <= bus.write_data;
                        first <= 1'b1;
                        bus.req_ready <= 1'b0;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    first <= 1'b0;
                    if (hit) begin
                        if (r_we) dirty[idx][hway] <= 1'b1;
                        else bus.read_data <= data[hway][idx][off];
                        for (int w = 0; w < ASOC_SIZE; w++)
                            if (age[w][idx] < age[hway][idx]) age[w][idx] <= age[w][idx] + ASOC_BITS'(1);
                        age[hway][idx] <= '0;
                        if (first && ~&bus.hit_count) bus.hit_count <= bus.hit_count + COUNT_BITS'(1);
                        bus.resp_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        vic <= vway;
                        if (first && ~&bus.miss_count) bus.miss_count <= bus.miss_count + COUNT_BITS'(1);
                        bus.mem_req_valid <= 1'b1;
                        if (valid[idx][vway] && dirty[idx][vway]) begin
                            bus.mem_write_en <= 1'b1;
                            bus.mem_address <= {tags[vway][idx], idx, {BLOCK_BITS{1'b0}}};
                            bus.mem_write_data <= data[vway][idx];
                            state <= WB_REQ;
                        end else begin
                            bus.mem_write_en <= 1'b0;
                            bus.mem_address <= {rtag, idx, {BLOCK_BITS{1'b0}}};
                            state <= RF_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    if (bus.mem_req_ready) begin
                        dirty[idx][vic] <= 1'b0;
                        bus.mem_write_en <= 1'b0;
                        bus.mem_address <= {rtag, idx, {BLOCK_BITS{1'b0}}};
                        state <= RF_REQ;
                    end
                end
                RF_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state <= RF_WAIT;
                    end
                end
                RF_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        valid[idx][vic] <= 1'b1;
                        dirty[idx][vic] <= 1'b0;
                        state <= LOOKUP;
                    end
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_assoc_wb.sv
// tb_cache_assoc_wb: directed and random checks of cache_assoc_wb against a flat-memory model
module tb_cache_assoc_wb;
    localparam int CB = 4;
    localparam int WAYS = 2;
    localparam int SETS = 4;
    localparam int CMAX = (1 << CB) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_assoc_wb_if #(.RAM_ADDRESS_BITS(10), .DATA_BITS(32), .BLOCK_BITS(2), .COUNT_BITS(CB)) bus();
    cache_assoc_wb #(
        .RAM_ADDRESS_BITS(10), .CACHE_ADDRESS_BITS(5), .DATA_BITS(32),
        .ASOC_BITS(1), .BLOCK_BITS(2), .COUNT_BITS(CB)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    int k;
    logic [31:0] ref_mem [1024];
    logic [31:0] bmem [1024];
    bit mv [SETS][WAYS];
    bit md [SETS][WAYS];
    logic [5:0] mt [SETS][WAYS];
    int ms [SETS][WAYS];
    int stamp;
    int hc;
    int mc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    function automatic logic [127:0] ref_blk(input logic [9:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = ref_mem[b + 10'(i)];
        return r;
    endfunction

    function automatic logic [127:0] bmem_blk(input logic [9:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = bmem[b + 10'(i)];
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
                ms[s][w] = 0;
            end
        stamp = 0;
        hc = 0;
        mc = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = bmem[i];
    endtask

    task automatic do_reset();
        bus.req_valid = 0;
        bus.mem_req_ready = 0;
        bus.mem_resp_valid = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_miss", bus.miss, 0);
        check("rst_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_mem_write_en", bus.mem_write_en, 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_read_data", bus.read_data, 0);
        check("rst_hit_count", bus.hit_count, 0);
        check("rst_miss_count", bus.miss_count, 0);
        model_reset();
    endtask

    task automatic mem_xfer(input bit we, input logic [9:0] ea, input logic [127:0] ed, input int d);
        int n;
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i <= d; i++) begin
            check("mem_req_valid", bus.mem_req_valid, 1);
            check("mem_write_en", bus.mem_write_en, we);
            check("mem_address", bus.mem_address, ea);
            if (we) check("mem_write_data", bus.mem_write_data, ed);
            check("busy_req_ready", bus.req_ready, 0);
            if (i == d) begin
                bus.mem_req_ready = 1;
                if (we) for (int j = 0; j < 4; j++) bmem[ea + 10'(j)] = bus.mem_write_data[j];
            end
            step();
        end
        bus.mem_req_ready = 0;
    endtask

    task automatic do_req(input logic [9:0] a, input bit we, input logic [31:0] wd,
                          input int dwb, input int drf, input int drsp,
                          output logic [31:0] rd, output logic [9:0] wba, output logic [127:0] wbd);
        logic [1:0] s;
        logic [5:0] t;
        logic [9:0] rfa;
        int w;
        int v;
        int n;
        bit h;
        bit wb;
        s = a[3:2];
        t = a[9:4];
        h = 0;
        w = 0;
        for (int i = 0; i < WAYS; i++) if (mv[s][i] && mt[s][i] == t) begin h = 1; w = i; end
        v = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) v = i;
        if (v < 0) begin
            v = 0;
            for (int i = 1; i < WAYS; i++) if (ms[s][i] < ms[s][v]) v = i;
        end
        wb = !h && mv[s][v] && md[s][v];
        wba = wb ? {mt[s][v], s, 2'b00} : 10'h3ff;
        wbd = wb ? ref_blk(wba) : '0;
        rfa = {t, s, 2'b00};
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", bus.req_ready, 1);
        bus.req_valid = 1;
        bus.address = a;
        bus.write_en = we;
        bus.write_data = wd;
        k = 0;
        step();
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.address = 10'($urandom);
        bus.write_en = 1'($urandom_range(0, 1));
        bus.write_data = $urandom;
        check("miss", bus.miss, !h);
        if (!h) begin
            if (wb) mem_xfer(1, wba, wbd, dwb);
            mem_xfer(0, rfa, '0, drf);
            repeat (drsp) step();
            bus.mem_resp_valid = 1;
            bus.mem_data = bmem_blk(rfa);
            step();
            bus.mem_resp_valid = 0;
            bus.mem_data = {$urandom, $urandom, $urandom, $urandom};
        end
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            step();
            n++;
        end
        bus.req_valid = 0;
        check("resp_valid", bus.resp_valid, 1);
        check("latency", k, h ? 2 : 5 + (wb ? 1 + dwb : 0) + drf + drsp);
        check("miss_low", bus.miss, 0);
        rd = we ? '0 : bus.read_data;
        if (!we) check("read_data", bus.read_data, ref_mem[a]);
        if (h) hc = hc == CMAX ? CMAX : hc + 1;
        else begin
            mc = mc == CMAX ? CMAX : mc + 1;
            mv[s][v] = 1;
            md[s][v] = 0;
            mt[s][v] = t;
            w = v;
        end
        stamp++;
        ms[s][w] = stamp;
        if (we) begin
            md[s][w] = 1;
            ref_mem[a] = wd;
        end
        check("hit_count", bus.hit_count, hc);
        check("miss_count", bus.miss_count, mc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [9:0] wba;
        logic [127:0] wbd;
        logic [9:0] a;
        int n;
        for (int i = 0; i < 1024; i++) bmem[i] = $urandom;
        bmem[16] = 32'hA0;
        bmem[17] = 32'hA1;
        bmem[18] = 32'hA2;
        bmem[19] = 32'hA3;
        bus.address = '0;
        bus.write_en = 0;
        bus.write_data = '0;
        bus.mem_data = '0;
        do_reset();

        do_req(10'h010, 0, 0, 0, 0, 0, rd, wba, wbd);
        check("d_read_010", rd, 32'hA0);
        check("d_miss_count_1", bus.miss_count, 1);
        do_req(10'h013, 0, 0, 0, 0, 0, rd, wba, wbd);
        check("d_read_013", rd, 32'hA3);
        check("d_hit_count_1", bus.hit_count, 1);
        do_req(10'h011, 1, 32'h55, 0, 0, 0, rd, wba, wbd);
        do_req(10'h050, 0, 0, 0, 0, 0, rd, wba, wbd);
        do_req(10'h090, 0, 0, 0, 0, 1, rd, wba, wbd);
        check("d_wb_address", wba, 10'h010);
        check("d_wb_data", wbd, {32'hA3, 32'hA2, 32'h55, 32'hA0});
        do_req(10'h050, 0, 0, 0, 0, 0, rd, wba, wbd);
        check("d_lru_hit_050", bus.hit_count, 3);
        do_req(10'h110, 0, 0, 0, 5, 0, rd, wba, wbd);

        do_reset();
        bus.req_valid = 1;
        bus.address = 10'h010;
        bus.write_en = 0;
        step();
        bus.req_valid = 0;
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            step();
            n++;
        end
        check("rst_rf_req", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1;
        step();
        bus.mem_req_ready = 0;
        reset = 1;
        step();
        step();
        reset = 0;
        bus.mem_resp_valid = 1;
        bus.mem_data = {32'h1, 32'h2, 32'h3, 32'h4};
        step();
        bus.mem_resp_valid = 0;
        step();
        check("late_req_ready", bus.req_ready, 1);
        check("late_mem_req_valid", bus.mem_req_valid, 0);
        check("late_miss_count", bus.miss_count, 0);
        model_reset();
        do_req(10'h010, 0, 0, 0, 0, 0, rd, wba, wbd);
        check("late_remiss", bus.miss_count, 1);
        check("late_read_010", rd, 32'hA0);

        for (int i = 0; i < 20; i++) do_req(10'h010 + 10'(i % 4), 0, 0, 0, 0, 0, rd, wba, wbd);
        check("sat_hit_count", bus.hit_count, CMAX);

        for (int i = 0; i < 400; i++) begin
            a = {6'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(a, $urandom_range(0, 4) < 2, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), rd, wba, wbd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
